// File: rtl/sd_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package sd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } sd_state_e;

  localparam logic [3:0] SD_PAT_1011 = 4'b1011;

endpackage

// File: rtl/sd_pattern_tx_if.sv
// Control/stream bundle between a pattern transmitter and whatever drives it.
interface sd_pattern_tx_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] rpt_cnt;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             signal;
  logic             valid;
  logic             frame_start;
  logic             busy;
  logic             done;

  modport master (
    output start, rpt_cnt, gap, abort,
    input  signal, valid, frame_start, busy, done
  );

  modport slave (
    input  start, rpt_cnt, gap, abort,
    output signal, valid, frame_start, busy, done
  );
endinterface

// File: rtl/sd_pattern_tx_shifter.sv
// Parallel-load MSB-out pattern register; rotates so o_next always shows the
// bit that follows the one currently on the line.
module sd_pattern_shifter #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_shift,
  output logic o_next,
  output logic o_last
);
  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] r_sh;
  logic [IW-1:0]    r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sh  <= PATTERN;
      r_idx <= '0;
    end else if (i_shift) begin
      r_sh  <= {r_sh[PAT_W-2:0], r_sh[PAT_W-1]};
      r_idx <= r_idx + IW'(1);
    end
  end

  assign o_next = r_sh[PAT_W-2];
  assign o_last = (r_idx == IW'(PAT_W - 1));
endmodule

// File: rtl/sd_pattern_tx.sv
// Serial pattern transmitter: repeats PATTERN MSB-first rpt_cnt times with a
// programmable idle gap; all outputs come straight from flops.
module sd_pattern_tx
  import sd_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = SD_PAT_1011,
  parameter int               CNT_W   = 8,
  parameter int               GAP_W   = 4
) (
  input logic         clk,
  input logic         rst,
  sd_pattern_tx_if.slave bus
);
  sd_state_e        r_state;
  logic [CNT_W-1:0] r_rpt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gcnt;
  logic             r_signal, r_valid, r_frame_start, r_busy, r_done;

  logic w_accept, w_reload, w_load, w_shift, w_next, w_last;

  // r_rpt holds the repetitions still owed, including the one on the line.
  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort && (bus.rpt_cnt != '0);
  assign w_reload = !bus.abort &&
                    (((r_state == S_SEND) && w_last && (r_rpt != CNT_W'(1)) && (r_gap == '0)) ||
                     ((r_state == S_GAP) && (r_gcnt == GAP_W'(1))));
  assign w_load   = w_accept || w_reload;
  assign w_shift  = (r_state == S_SEND) && !w_last && !bus.abort;

  sd_pattern_shifter #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_shift(w_shift),
    .o_next (w_next),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rpt         <= '0;
      r_gap         <= '0;
      r_gcnt        <= '0;
      r_signal      <= 1'b0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        r_signal <= 1'b0;
        r_valid  <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_rpt <= bus.rpt_cnt;
              r_gap <= bus.gap;
              if (bus.rpt_cnt == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state       <= S_SEND;
                r_signal      <= PATTERN[PAT_W-1];
                r_valid       <= 1'b1;
                r_frame_start <= 1'b1;
                r_busy        <= 1'b1;
              end
            end
          end
          S_SEND: begin
            if (!w_last) begin
              r_signal <= w_next;
            end else if (r_rpt == CNT_W'(1)) begin
              r_state  <= S_DONE;
              r_signal <= 1'b0;
              r_valid  <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_rpt <= r_rpt - CNT_W'(1);
              if (r_gap == '0) begin
                r_signal      <= PATTERN[PAT_W-1];
                r_frame_start <= 1'b1;
              end else begin
                r_state  <= S_GAP;
                r_gcnt   <= r_gap;
                r_signal <= 1'b0;
                r_valid  <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (r_gcnt == GAP_W'(1)) begin
              r_state       <= S_SEND;
              r_signal      <= PATTERN[PAT_W-1];
              r_valid       <= 1'b1;
              r_frame_start <= 1'b1;
            end else begin
              r_gcnt <= r_gcnt - GAP_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.signal      = r_signal;
  assign bus.valid       = r_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_sd_pattern_tx.sv
// Scoreboard bench: stimulus predicts every output event into a queue from
// the timing rules; a negedge monitor pops and compares.
module tb_sd_pattern_tx;
  localparam int P = 4;

  typedef struct {
    int cyc;
    bit is_done;
    bit sig;
    bit fs;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  ev_t  q[$];
  int   b_lo = 1, b_hi = 0;
  int   free_c = 0;
  int   cur_t = 0;
  int   last_done = 0;
  logic [P-1:0] pat = 4'b1011;

  sd_pattern_tx_if #(.CNT_W(8), .GAP_W(4)) bus ();

  sd_pattern_tx #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  ev_t e;
  bit  exp_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.valid || bus.done) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output cyc=%0d valid=%b done=%b signal=%b fs=%b, required none",
                   cyc, bus.valid, bus.done, bus.signal, bus.frame_start);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || bus.valid != !e.is_done || bus.done != e.is_done ||
              bus.signal != e.sig || bus.frame_start != e.fs) begin
            n_err++;
            $display("FAIL event got cyc=%0d v=%b d=%b s=%b fs=%b required cyc=%0d v=%b d=%b s=%b fs=%b",
                     cyc, bus.valid, bus.done, bus.signal, bus.frame_start,
                     e.cyc, !e.is_done, e.is_done, e.sig, e.fs);
          end
        end
      end else begin
        n_cmp++;
        if (bus.signal || bus.frame_start) begin
          n_err++;
          $display("FAIL idle_quiet cyc=%0d signal=%b fs=%b required 0 0",
                   cyc, bus.signal, bus.frame_start);
        end
      end
      exp_busy = (cyc >= b_lo) && (cyc <= b_hi);
      n_cmp++;
      if (bus.busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, bus.busy, exp_busy);
      end
    end
  end

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < c) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_timeout got cyc=%0d required %0d", cyc, c);
    end
  endtask

  // Issue an accepted start and predict its whole output stream.
  task automatic start_xfer(input int rpt, input int g);
    int t, last;
    wait_cyc(free_c);
    t = cyc + 1;
    cur_t = t;
    bus.start   = 1'b1;
    bus.rpt_cnt = 8'(rpt);
    bus.gap     = 4'(g);
    if (rpt == 0) begin
      q.push_back('{t, 1'b1, 1'b0, 1'b0});
      last_done = t;
      free_c = t + 1;
    end else begin
      for (int r = 0; r < rpt; r++)
        for (int k = 0; k < P; k++)
          q.push_back('{t + r * (P + g) + k, 1'b0, pat[P-1-k], k == 0});
      last = t + (rpt - 1) * (P + g) + P - 1;
      q.push_back('{last + 1, 1'b1, 1'b0, 1'b0});
      b_lo = t;
      b_hi = last;
      last_done = last + 1;
      free_c = last + 2;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.rpt_cnt = 8'($urandom);
    bus.gap     = 4'($urandom);
  endtask

  task automatic stray_start();
    bus.start   = 1'b1;
    bus.rpt_cnt = 8'($urandom_range(1, 255));
    bus.gap     = 4'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Abort (or reset) sampled at the next edge: nothing predicted past it survives.
  task automatic kill(input bit use_rst);
    int c = cyc;
    if (use_rst) rst = 1'b1;
    else bus.abort = 1'b1;
    while (q.size() > 0 && q[$].cyc >= c + 1) void'(q.pop_back());
    if (b_hi > c) b_hi = c;
    if (free_c > c + 1) free_c = c + 1;
    @(negedge clk);
    rst = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    int r, o, rpt, g, n;
    bus.start = 1'b0;
    bus.rpt_cnt = '0;
    bus.gap = '0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.signal, bus.valid, bus.frame_start, bus.busy, bus.done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_state got=%b required=00000",
               {bus.signal, bus.valid, bus.frame_start, bus.busy, bus.done});
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    free_c = cyc;

    start_xfer(1, 0);
    start_xfer(3, 2);
    start_xfer(2, 0);
    start_xfer(0, 7);
    stray_start();                 // lands while in DONE
    start_xfer(5, 1);
    wait_cyc(cur_t + 2);
    stray_start();                 // lands mid-transfer

    start_xfer(3, 1);              // abort after third bit of second repetition
    wait_cyc(cur_t + (P + 1) + 2);
    kill(1'b0);
    start_xfer(1, 0);

    wait_cyc(free_c);              // abort and start together in IDLE
    bus.abort = 1'b1;
    stray_start();
    bus.abort = 1'b0;

    start_xfer(2, 3);              // reset during the gap
    wait_cyc(cur_t + P);
    kill(1'b1);
    start_xfer(1, 0);

    start_xfer(255, 0);

    for (int i = 0; i < 40; i++) begin
      rpt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      g = $urandom_range(0, 15);
      start_xfer(rpt, g);
      r = $urandom_range(0, 9);
      if (r < 2) begin
        o = $urandom_range(0, last_done - cur_t + 1);
        wait_cyc(cur_t + o);
        kill(r == 1);
      end else if (r == 2) begin
        wait_cyc(cur_t + $urandom_range(0, last_done - cur_t));
        stray_start();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (q.size() > 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending events required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
